// File: rtl/alu_pipe.sv
// Pipelined integer ALU execution unit: compute in stage 0, later stages are elastic delay.
// Define LEN5_ALU_WORD_OPS_EN to build the 32-bit word ops (codes 10-14).
module alu_pipe #(
  parameter  int unsigned XLEN       = 64,
  parameter  int unsigned RS_DEPTH   = 16,
  parameter  int unsigned PIPE_DEPTH = 1,
  parameter  int unsigned EU_CTL_LEN = 4,
  parameter  int unsigned EXCEPT_LEN = 2,
  parameter  int unsigned ILL_CODE   = 2,
  localparam int unsigned IDX_W      = $clog2(RS_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [IDX_W-1:0]      issue_idx_i,
  input  logic [EU_CTL_LEN-1:0] issue_ctl_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [XLEN-1:0]       issue_rs2_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [IDX_W-1:0]      res_idx_o,
  output logic [XLEN-1:0]       res_value_o,
  output logic                  res_except_o,
  output logic [EXCEPT_LEN-1:0] res_except_code_o
);

  localparam int unsigned SH_W = $clog2(XLEN);

  localparam logic [EU_CTL_LEN-1:0] OP_ADD  = EU_CTL_LEN'(0);
  localparam logic [EU_CTL_LEN-1:0] OP_SUB  = EU_CTL_LEN'(1);
  localparam logic [EU_CTL_LEN-1:0] OP_AND  = EU_CTL_LEN'(2);
  localparam logic [EU_CTL_LEN-1:0] OP_OR   = EU_CTL_LEN'(3);
  localparam logic [EU_CTL_LEN-1:0] OP_XOR  = EU_CTL_LEN'(4);
  localparam logic [EU_CTL_LEN-1:0] OP_SLL  = EU_CTL_LEN'(5);
  localparam logic [EU_CTL_LEN-1:0] OP_SRL  = EU_CTL_LEN'(6);
  localparam logic [EU_CTL_LEN-1:0] OP_SRA  = EU_CTL_LEN'(7);
  localparam logic [EU_CTL_LEN-1:0] OP_SLT  = EU_CTL_LEN'(8);
  localparam logic [EU_CTL_LEN-1:0] OP_SLTU = EU_CTL_LEN'(9);
`ifdef LEN5_ALU_WORD_OPS_EN
  localparam logic [EU_CTL_LEN-1:0] OP_ADDW = EU_CTL_LEN'(10);
  localparam logic [EU_CTL_LEN-1:0] OP_SUBW = EU_CTL_LEN'(11);
  localparam logic [EU_CTL_LEN-1:0] OP_SLLW = EU_CTL_LEN'(12);
  localparam logic [EU_CTL_LEN-1:0] OP_SRLW = EU_CTL_LEN'(13);
  localparam logic [EU_CTL_LEN-1:0] OP_SRAW = EU_CTL_LEN'(14);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  logic [31:0] rs1_w;
  logic [31:0] rs2_w;
  logic [4:0]  shw;
  assign rs1_w = issue_rs1_i[31:0];
  assign rs2_w = issue_rs2_i[31:0];
  assign shw   = issue_rs2_i[4:0];
`endif

  logic [XLEN-1:0] res_c;
  logic            ill_c;
  logic [SH_W-1:0] shamt;
  assign shamt = issue_rs2_i[SH_W-1:0];

  // Stage-0 datapath
  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    case (issue_ctl_i)
      OP_ADD:  res_c = issue_rs1_i + issue_rs2_i;
      OP_SUB:  res_c = issue_rs1_i - issue_rs2_i;
      OP_AND:  res_c = issue_rs1_i & issue_rs2_i;
      OP_OR:   res_c = issue_rs1_i | issue_rs2_i;
      OP_XOR:  res_c = issue_rs1_i ^ issue_rs2_i;
      OP_SLL:  res_c = issue_rs1_i << shamt;
      OP_SRL:  res_c = issue_rs1_i >> shamt;
      OP_SRA:  res_c = $signed(issue_rs1_i) >>> shamt;
      OP_SLT:  res_c = XLEN'($signed(issue_rs1_i) < $signed(issue_rs2_i));
      OP_SLTU: res_c = XLEN'(issue_rs1_i < issue_rs2_i);
`ifdef LEN5_ALU_WORD_OPS_EN
      OP_ADDW: res_c = sext32(rs1_w + rs2_w);
      OP_SUBW: res_c = sext32(rs1_w - rs2_w);
      OP_SLLW: res_c = sext32(rs1_w << shw);
      OP_SRLW: res_c = sext32(rs1_w >> shw);
      OP_SRAW: res_c = sext32($signed(rs1_w) >>> shw);
`endif
      default: ill_c = 1'b1;
    endcase
  end

  logic [PIPE_DEPTH-1:0] v_q, v_d, adv_c, ld_c;
  logic [XLEN-1:0]       val_q  [PIPE_DEPTH];
  logic [IDX_W-1:0]      idx_q  [PIPE_DEPTH];
  logic                  exc_q  [PIPE_DEPTH];
  logic [EXCEPT_LEN-1:0] code_q [PIPE_DEPTH];
  logic [XLEN-1:0]       val_in  [PIPE_DEPTH];
  logic [IDX_W-1:0]      idx_in  [PIPE_DEPTH];
  logic                  exc_in  [PIPE_DEPTH];
  logic [EXCEPT_LEN-1:0] code_in [PIPE_DEPTH];
  logic                  rdy_c, nxt_ok, prev_adv;

  for (genvar g = 0; g < int'(PIPE_DEPTH); g++) begin : g_stage_in
    if (g == 0) begin : g_head
      assign val_in[g]  = res_c;
      assign idx_in[g]  = issue_idx_i;
      assign exc_in[g]  = ill_c;
      assign code_in[g] = ill_c ? EXCEPT_LEN'(ILL_CODE) : '0;
    end else begin : g_tail
      assign val_in[g]  = val_q[g-1];
      assign idx_in[g]  = idx_q[g-1];
      assign exc_in[g]  = exc_q[g-1];
      assign code_in[g] = code_q[g-1];
    end
  end

  // Back-pressure ripples from the result port towards issue
  always_comb begin
    adv_c    = '0;
    ld_c     = '0;
    v_d      = '0;
    nxt_ok   = res_ready_i;
    for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
      adv_c[k] = v_q[k] & nxt_ok;
      nxt_ok   = !v_q[k] | adv_c[k];
    end
    rdy_c    = nxt_ok;
    prev_adv = issue_valid_i & nxt_ok;
    for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
      ld_c[k]  = prev_adv;
      prev_adv = adv_c[k];
      v_d[k]   = !flush_i & (ld_c[k] | (v_q[k] & !adv_c[k]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q <= '0;
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        val_q[k]  <= '0;
        idx_q[k]  <= '0;
        exc_q[k]  <= 1'b0;
        code_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        if (ld_c[k] && !flush_i) begin
          val_q[k]  <= val_in[k];
          idx_q[k]  <= idx_in[k];
          exc_q[k]  <= exc_in[k];
          code_q[k] <= code_in[k];
        end
      end
    end
  end

  assign issue_ready_o     = rdy_c;
  assign res_valid_o       = v_q[PIPE_DEPTH-1];
  assign res_value_o       = val_q[PIPE_DEPTH-1];
  assign res_idx_o         = idx_q[PIPE_DEPTH-1];
  assign res_except_o      = exc_q[PIPE_DEPTH-1];
  assign res_except_code_o = code_q[PIPE_DEPTH-1];

endmodule
